// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
//   Bit-serial subtractor. It computes (a_in - b_in - c_in) mod 2^WIDTH over
//   WIDTH cycles, LSB first, through a single-bit full-subtractor cell. The
//   result appears only when the operation completes, and the final borrow
//   indicates unsigned underflow.
//
//   Ports
//     clk_in      : clock; all state updates on its rising edge
//     rst_in      : synchronous active-high reset
//     start_in    : request, sampled only in IDLE or DONE
//     a_in, b_in  : minuend / subtrahend, captured on the accepting edge
//     c_in        : initial borrow-in, captured on the accepting edge
//     busy_out    : high while the operation runs
//     done_out    : one-cycle pulse when diff_out/borrow_out are new
//     diff_out    : registered result
//     borrow_out  : registered final borrow (1 iff a < b + c)
// -----------------------------------------------------------------------------

// Single-bit full subtractor built from gates:
// diff_out = a - b - borrow_in (mod 2), and borrow_out is the borrow from that bit.
module full_sub_structural (
  input  logic a_in,
  input  logic b_in,
  input  logic borrow_in,
  output logic diff_out,
  output logic borrow_out
);
  logic ab_xor;
  logic b_gt_a;
  logic eq_borrow;

  assign ab_xor     = a_in ^ b_in;
  assign diff_out   = ab_xor ^ borrow_in;
  assign b_gt_a     = ~a_in & b_in;
  // When a == b the incoming borrow passes straight through.
  assign eq_borrow  = ~ab_xor & borrow_in;
  assign borrow_out = b_gt_a | eq_borrow;
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] r_sh_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             brw_reg;
  logic             borrow_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CW-1:0]    cnt_reg;

  logic             cell_diff;
  logic             cell_borrow;
  logic [WIDTH-1:0] r_sh_next;
  logic             accept;

  full_sub_structural u_cell (
    .a_in       (a_sh_reg[0]),
    .b_in       (b_sh_reg[0]),
    .borrow_in  (brw_reg),
    .diff_out   (cell_diff),
    .borrow_out (cell_borrow)
  );

  // Each new difference bit enters at the MSB, so after WIDTH shifts the
  // first (LSB) bit has reached position 0.
  assign r_sh_next = {cell_diff, r_sh_reg[WIDTH-1:1]};

  // A start is honoured only when no operation is in flight.
  assign accept = start_in && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg  <= ST_IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      r_sh_reg   <= '0;
      diff_reg   <= '0;
      brw_reg    <= 1'b0;
      borrow_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_reg <= ST_RUN;
            a_sh_reg  <= a_in;
            b_sh_reg  <= b_in;
            brw_reg   <= c_in;
            r_sh_reg  <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_sh_reg <= r_sh_next;
          brw_reg  <= cell_borrow;
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          cnt_reg  <= cnt_reg + CW'(1);
          if (cnt_reg == CNT_LAST) begin
            // Publish using this cycle's bit, not the registered partial.
            state_reg  <= ST_DONE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            diff_reg   <= r_sh_next;
            borrow_reg <= cell_borrow;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_out   = busy_reg;
  assign done_out   = done_reg;
  assign diff_out   = diff_reg;
  assign borrow_out = borrow_reg;
endmodule
